// File: rtl/psum_drain_ctrl_pkg.sv
// Shared register-file and PE-control types plus drain-controller constants.
// RFCfg/PECtlCfg hold pad geometry and beat formats; psum_drain_ctrl_pkg holds FSM encodings.
package RFCfg;
  localparam int PPADADDRWD = 4;
  localparam int PSUMWD     = 32;

  typedef enum logic {
    D16 = 1'b0,
    D32 = 1'b1
  } PsumMode;
endpackage

package PECtlCfg;
  import RFCfg::*;

  localparam int PEROWWD = 4;

  typedef struct packed {
    logic                  read;
    logic [PPADADDRWD-1:0] raddr;
    logic                  write;
    logic [PPADADDRWD-1:0] waddr;
  } PPctl;

  typedef struct packed {
    logic [PSUMWD-1:0]  data;
    logic [PEROWWD-1:0] col;
    PsumMode            mode;
    logic               last;
  } PSOutBeat;
endpackage

package psum_drain_ctrl_pkg;
  import RFCfg::*;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int FIFO_DEPTH = 2;

  // D16 packs two halves per entry, so only even addresses are read
  function automatic logic [PPADADDRWD:0] drain_reads(input logic [PPADADDRWD:0] size,
                                                      input PsumMode             mode);
    logic [PPADADDRWD+1:0] w_sum;
    w_sum = {1'b0, size} + {{(PPADADDRWD+1){1'b0}}, 1'b1};
    return (mode == D16) ? w_sum[PPADADDRWD+1:1] : size;
  endfunction
endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Beat channel with rdy/ack handshake; master drives rdy and beat, slave answers with ack.
interface psum_drain_ctrl_if;
  import PECtlCfg::*;

  logic     rdy;
  logic     ack;
  PSOutBeat beat;

  modport master (output rdy, output beat, input ack);
  modport slave  (input rdy, input beat, output ack);
endinterface

// File: rtl/psum_skid_fifo.sv
// Two-entry skid buffer; an empty buffer forwards the incoming beat straight to the output.
module psum_skid_fifo
  import PECtlCfg::*;
  import psum_drain_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  psum_drain_ctrl_if.slave  s_in,
  psum_drain_ctrl_if.master m_out,
  output logic [1:0]        o_count
);

  PSOutBeat   r_mem [FIFO_DEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;

  logic w_empty;
  logic w_bypass;
  logic w_pop;
  logic w_push;

  assign w_empty    = (r_count == 2'd0);
  assign m_out.rdy  = !w_empty || s_in.rdy;
  assign m_out.beat = !w_empty ? r_mem[r_head] : (s_in.rdy ? s_in.beat : '0);

  // push+pop on an empty buffer passes through without touching storage
  assign w_bypass = w_empty && s_in.rdy && m_out.ack;
  assign w_pop    = !w_empty && m_out.ack;
  assign w_push   = s_in.rdy && !w_bypass && ((r_count != 2'd2) || w_pop);
  assign s_in.ack = w_bypass || w_push;
  assign o_count  = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (i_clear) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= s_in.beat;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains the psum pad into rdy/ack output beats through a 2-entry skid buffer.
// IDLE | waiting for start ; DRAIN | issuing pad reads ; FLUSH | emptying reads in flight and buffer
module psum_drain_ctrl
  import PECtlCfg::*;
  import psum_drain_ctrl_pkg::*;
#(
  parameter logic [PEROWWD-1:0] PECOLIDX   = '0,
  parameter int                 PPADADDRWD = RFCfg::PPADADDRWD,
  parameter int                 PSUMWD     = RFCfg::PSUMWD
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic [PPADADDRWD:0] i_ppad_size,
  input  RFCfg::PsumMode      i_psum_mode,
  output PPctl                o_PSPPctl,
  input  logic [PSUMWD-1:0]   i_pp_rdata,
  output logic                PSOut_rdy,
  input  logic                PSOut_ack,
  output PSOutBeat            o_PSOut,
  output logic                o_busy,
  output logic                o_done
);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [PPADADDRWD:0]   r_rem;
  logic [PPADADDRWD-1:0] r_raddr;
  logic [PPADADDRWD-1:0] w_step;
  RFCfg::PsumMode        r_mode;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_zero_done;
  logic [1:0]            w_fifo_cnt;

  logic w_start;
  logic w_read;
  logic w_final_rd;
  logic w_flush_done;

  psum_drain_ctrl_if w_in_if ();
  psum_drain_ctrl_if w_out_if ();

  assign w_start = i_start && !i_clear && (r_state == ST_IDLE);

  // at most two entries buffered or in flight, so the skid buffer never overflows
  assign w_read = (r_state == ST_DRAIN) && !i_clear &&
                  (({1'b0, w_fifo_cnt} + {2'b00, r_inflight}) < 3'd2);
  assign w_final_rd   = w_read && (r_rem == {{PPADADDRWD{1'b0}}, 1'b1});
  assign w_flush_done = (r_state == ST_FLUSH) && (w_fifo_cnt == 2'd0) &&
                        !r_inflight && !i_clear;

  assign w_step = {{(PPADADDRWD-2){1'b0}}, (r_mode == RFCfg::D16), (r_mode == RFCfg::D32)};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start && (i_ppad_size != '0)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_final_rd) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_rem           <= '0;
      r_raddr         <= '0;
      r_mode          <= RFCfg::D16;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_zero_done     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_read;
      r_inflight_last <= w_final_rd;
      r_zero_done     <= w_start && (i_ppad_size == '0);
      if (w_start) begin
        r_mode  <= i_psum_mode;
        r_rem   <= drain_reads(i_ppad_size, i_psum_mode);
        r_raddr <= '0;
      end else if (w_read) begin
        r_rem <= r_rem - {{PPADADDRWD{1'b0}}, 1'b1};
        if (!w_final_rd) begin
          r_raddr <= r_raddr + w_step;
        end
      end
    end
  end

  assign w_in_if.rdy  = r_inflight;
  assign w_in_if.beat = '{data: i_pp_rdata, col: PECOLIDX, mode: r_mode, last: r_inflight_last};

  psum_skid_fifo u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .s_in    (w_in_if),
    .m_out   (w_out_if),
    .o_count (w_fifo_cnt)
  );

  a_no_drop: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                              w_in_if.rdy |-> w_in_if.ack);

  assign w_out_if.ack = PSOut_ack;
  assign PSOut_rdy    = w_out_if.rdy;
  assign o_PSOut      = w_out_if.beat;
  assign o_PSPPctl    = '{read: w_read, raddr: r_raddr, write: 1'b0, waddr: '0};
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = w_flush_done || (r_zero_done && !i_clear);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed cycle-by-cycle vectors for psum_drain_ctrl with a synchronous pad model.
`timescale 1ns/1ps
module tb_psum_drain_ctrl;
  import RFCfg::*;
  import PECtlCfg::*;

  localparam logic [PEROWWD-1:0] COL = 4'd5;
  localparam logic [PSUMWD-1:0]  PAT = 32'hCAFE_0000;

  typedef struct {
    logic       start;
    logic       clear;
    logic [4:0] size;
    PsumMode    mode;
    logic       ack;
    logic       rdy;
    logic       read;
    logic [3:0] raddr;
    logic       busy;
    logic       done;
    logic       last;
    logic [3:0] daddr;
    PsumMode    bmode;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clear;
  logic [4:0]        size;
  PsumMode           mode;
  PPctl              pp_ctl;
  logic [PSUMWD-1:0] pp_rdata = '0;
  logic              busy;
  logic              done;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  psum_drain_ctrl_if ps_if ();

  psum_drain_ctrl #(.PECOLIDX(COL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_clear     (clear),
    .i_ppad_size (size),
    .i_psum_mode (mode),
    .o_PSPPctl   (pp_ctl),
    .i_pp_rdata  (pp_rdata),
    .PSOut_rdy   (ps_if.rdy),
    .PSOut_ack   (ps_if.ack),
    .o_PSOut     (ps_if.beat),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pp_ctl.read) pp_rdata <= PAT + 32'(pp_ctl.raddr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input int st, input int cl, input int sz, input PsumMode md, input int ak,
                     input int rdy, input int rd, input int ra, input int bsy, input int dn,
                     input int lst, input int da, input PsumMode bm);
    vec_t v;
    v.start = st[0]; v.clear = cl[0]; v.size = 5'(sz); v.mode = md; v.ack = ak[0];
    v.rdy = rdy[0]; v.read = rd[0]; v.raddr = 4'(ra); v.busy = bsy[0]; v.done = dn[0];
    v.last = lst[0]; v.daddr = 4'(da); v.bmode = bm;
    vecs.push_back(v);
  endtask

  task automatic check_idle(input string tag, input int row);
    check({tag, "_rdy"},   row, 64'(ps_if.rdy),   64'd0);
    check({tag, "_busy"},  row, 64'(busy),        64'd0);
    check({tag, "_done"},  row, 64'(done),        64'd0);
    check({tag, "_read"},  row, 64'(pp_ctl.read), 64'd0);
    check({tag, "_raddr"}, row, 64'(pp_ctl.raddr), 64'd0);
    check({tag, "_beat"},  row, 64'(ps_if.beat),  64'd0);
  endtask

  initial begin
    PSOutBeat exp_beat;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; size = '0; mode = D16; ps_if.ack = 1'b0;

    // D32 size 5; a start in row 4 must be ignored
    add(1,0,5,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,1,0, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,1,1, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,1,2, 1,0,0,1, D32);
    add(1,0,1,D16,1, 1,1,3, 1,0,0,2, D32);
    add(0,0,0,D32,1, 1,1,4, 1,0,0,3, D32);
    add(0,0,0,D32,1, 1,0,0, 1,0,1,4, D32);
    add(0,0,0,D32,1, 0,0,0, 1,1,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    // D16 size 6: even addresses only
    add(1,0,6,D16,1, 0,0,0, 0,0,0,0, D16);
    add(0,0,0,D16,1, 0,1,0, 1,0,0,0, D16);
    add(0,0,0,D16,1, 1,1,2, 1,0,0,0, D16);
    add(0,0,0,D16,1, 1,1,4, 1,0,0,2, D16);
    add(0,0,0,D16,1, 1,0,0, 1,0,1,4, D16);
    add(0,0,0,D16,1, 0,0,0, 1,1,0,0, D16);
    add(0,0,0,D16,1, 0,0,0, 0,0,0,0, D16);
    // size 0
    add(1,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,1,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    // backpressure: size 4, ack low for relative cycles 2..6
    add(1,0,4,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,1,0, 1,0,0,0, D32);
    add(0,0,0,D32,0, 1,1,1, 1,0,0,0, D32);
    add(0,0,0,D32,0, 1,0,0, 1,0,0,0, D32);
    add(0,0,0,D32,0, 1,0,0, 1,0,0,0, D32);
    add(0,0,0,D32,0, 1,0,0, 1,0,0,0, D32);
    add(0,0,0,D32,0, 1,0,0, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,0,0, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,1,2, 1,0,0,1, D32);
    add(0,0,0,D32,1, 1,1,3, 1,0,0,2, D32);
    add(0,0,0,D32,1, 1,0,0, 1,0,1,3, D32);
    add(0,0,0,D32,1, 0,0,0, 1,1,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    // abort at cycle 3 of a size-8 drain, clear beats start, then size 2
    add(1,0,8,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,1,0, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,1,1, 1,0,0,0, D32);
    add(0,1,0,D32,1, 1,0,0, 1,0,0,1, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    add(1,1,2,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);
    add(1,0,2,D32,1, 0,0,0, 0,0,0,0, D32);
    add(0,0,0,D32,1, 0,1,0, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,1,1, 1,0,0,0, D32);
    add(0,0,0,D32,1, 1,0,0, 1,0,1,1, D32);
    add(0,0,0,D32,1, 0,0,0, 1,1,0,0, D32);
    add(0,0,0,D32,1, 0,0,0, 0,0,0,0, D32);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // outputs stay at reset values before the first start, whatever ack does
    for (int k = 0; k < 3; k++) begin
      ps_if.ack = k[0];
      @(negedge clk);
      check_idle("post_reset", k);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      start = vecs[i].start; clear = vecs[i].clear; size = vecs[i].size;
      mode = vecs[i].mode; ps_if.ack = vecs[i].ack;
      @(negedge clk);
      check("rdy",  i, 64'(ps_if.rdy),   64'(vecs[i].rdy));
      check("read", i, 64'(pp_ctl.read), 64'(vecs[i].read));
      check("busy", i, 64'(busy),        64'(vecs[i].busy));
      check("done", i, 64'(done),        64'(vecs[i].done));
      if (vecs[i].read) check("raddr", i, 64'(pp_ctl.raddr), 64'(vecs[i].raddr));
      if (vecs[i].rdy) begin
        exp_beat = '{data: PAT + 32'(vecs[i].daddr), col: COL, mode: vecs[i].bmode,
                     last: vecs[i].last};
        check("beat", i, 64'(ps_if.beat), 64'(exp_beat));
      end
    end

    // asynchronous reset in the middle of a drain
    @(posedge clk);
    #1;
    start = 1'b1; clear = 1'b0; size = 5'd8; mode = D32; ps_if.ack = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_rdy",  0, 64'(ps_if.rdy),   64'd1);
    check("pre_rst_busy", 0, 64'(busy),        64'd1);
    check("pre_rst_read", 0, 64'(pp_ctl.read), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst", 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_drain_ctrl.md
PSUM_DRAIN_CTRL -- requirements
Module: psum_drain_ctrl

Interface
REQ-001 SHALL have parameter PECOLIDX, default 0, meaning PE column index stamped on every output beat (width PEROWWD).
REQ-002 SHALL have parameter PPADADDRWD, default taken from RFCfg, meaning psum pad address width.
REQ-003 SHALL have parameter PSUMWD, default taken from RFCfg, meaning psum pad data width.
REQ-004 SHALL have port i_clk, input, 1 bit: the only clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1: one-cycle drain request, driven by the datapath controller on its confEnd status.
REQ-007 SHALL have port i_clear, input, 1: synchronous abort, driven by PE inst reset.
REQ-008 SHALL have port i_ppad_size, input, PPADADDRWD+1: number of pad entries to drain.
REQ-009 SHALL have port i_psum_mode, input, PsumMode: D16 or D32.
REQ-010 SHALL have port o_PSPPctl, output, PECtlCfg::PPctl: pad read port; write and waddr are tied 0.
REQ-011 SHALL have port i_pp_rdata, input, PSUMWD: pad read data, valid one cycle after read.
REQ-012 SHALL have port PSOut_rdy, output, 1: output beat valid.
REQ-013 SHALL have port PSOut_ack, input, 1: the consumer accepts the beat.
REQ-014 SHALL have port o_PSOut, output, PSOutBeat: {data PSUMWD, col PEROWWD, mode, last}.
REQ-015 SHALL have port o_busy, output, 1: high while not IDLE.
REQ-016 SHALL have port o_done, output, 1: one-cycle pulse after the last beat is transferred.

Function
REQ-017 SHALL use rdy/ack semantics: a beat transfers on PSOut_rdy && PSOut_ack; once raised, rdy and o_PSOut SHALL hold until the beat transfers.
REQ-018 SHALL implement FSM IDLE -> DRAIN -> FLUSH -> IDLE, with the following transitions:
- IDLE to DRAIN on i_start.
- DRAIN to FLUSH in the cycle after the final read issues.
- FLUSH to IDLE when the buffer is empty and no read is in flight; o_done SHALL pulse in that cycle.
REQ-019 SHALL latch i_ppad_size and i_psum_mode on i_start in IDLE; i_start in any other state SHALL be ignored.
REQ-020 SHALL treat i_ppad_size==0 on start as an immediate transition to IDLE, with an o_done pulse on the next cycle and no reads or beats.
REQ-021 SHALL drain addresses as follows:
- In D32 mode: read addresses 0,1,...,size-1.
- In D16 mode: read only the even addresses below size (0,2,4,...).
REQ-022 SHALL assert o_PSPPctl.read only when (buffered entries + in-flight reads) < 2, using a 2-entry skid FIFO.
REQ-023 SHALL load the FIFO with i_pp_rdata exactly one cycle after each read; the FIFO SHALL never overflow or drop data.
REQ-024 SHALL set the last flag only on the beat of the final read address.
REQ-025 SHALL deliver the first beat with PSOut_rdy 2 cycles after i_start (read at start+1, data at start+2), given continuous ack.
REQ-026 SHALL sustain a throughput of 1 beat/cycle under continuous ack.
REQ-027 SHALL handle a simultaneous FIFO push and pop as a count-neutral operation.
REQ-028 SHALL respond to i_clear in any state as follows:
- Next state IDLE.
- FIFO emptied and the in-flight read discarded.
- PSOut_rdy low next cycle.
- No o_done pulse.
- i_clear SHALL have priority over a coincident i_start.
REQ-029 SHALL drive o_PSPPctl.raddr from a registered counter; raddr SHALL never reach or exceed the latched size.

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously force:
- State IDLE.
- Counters 0 and FIFO empty.
- PSOut_rdy=0, o_busy=0, o_done=0, o_PSPPctl.read=0.
- o_PSOut=0.
REQ-031 SHALL keep all outputs at their reset values until the first i_start after reset release.

Structure
REQ-032 SHALL place PSOutBeat in PECtlCfg; PsumMode, PPADADDRWD and PSUMWD SHALL remain in their existing packages.
REQ-033 SHALL instantiate one sub-module, psum_skid_fifo (2-entry, rdy/ack on both sides).
REQ-034 SHALL have a total RTL size between 120 and 400 lines.

Verification
REQ-035 SHALL cover a D32 drain: size=5, ack held high -> raddr 0..4 on cycles 1..5, beats on cycles 2..6, last on data of address 4, o_done on cycle 7.
REQ-036 SHALL cover a D16 drain: size=6 -> reads 0,2,4 only, 3 beats, last on address 4.
REQ-037 SHALL cover backpressure: size=4 with ack low for cycles 2..6 -> at most 2 reads outstanding, beat 0 held stable, all 4 beats delivered in order with no loss.
REQ-038 SHALL cover abort: i_clear at cycle 3 of a size=8 drain -> PSOut_rdy=0 and o_busy=0 at cycle 4, no o_done; a new start with size=2 drains correctly.
REQ-039 SHALL cover size=0 start -> no read, no beat, o_done one cycle later.
REQ-040 SHALL cover asynchronous reset asserted mid-DRAIN -> all outputs at reset values immediately, without waiting for a clock edge.
